// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 scan code decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_ACK   = 8'hFA;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ERR0  = 8'h00;
    localparam logic [7:0] PS2_ERR1  = 8'hFF;

    // Bytes that follow E1 in the Pause make sequence
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event queue; the head entry is always visible on head_o.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  ps2_event_t               din_i,
    input  logic                     pop_i,
    output ps2_event_t               head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    ps2_event_t              mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [AW:0]             level_q;
    logic                    pop_en;
    logic                    push_en;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_en, pop_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns the Set-2 byte stream into make/break events and queues them.
//
// state      | meaning
// -----------+-------------------------------------------
// ST_IDLE    | no prefix seen
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 F0 seen
// ST_PAUSE   | swallowing the remaining Pause bytes
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [7:0]               ev_code,
    output logic                     ev_ext,
    output logic                     ev_break,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   ev_level,
    output logic                     ack_pulse,
    output logic                     bat_pulse,
    output logic                     kbd_err,
    output logic                     overflow,
    input  logic                     clr_flags
);
    ps2_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        push_d;
    ps2_event_t  ev_d;
    logic        ack_d, bat_d, err_d;
    logic        ack_q, bat_q, err_q, ovf_q;
    ps2_event_t  head;
    logic        fifo_empty, fifo_full;

    // Next-state decode of the current byte; the event is pushed on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push_d  = 1'b0;
        ev_d    = '0;
        ack_d   = 1'b0;
        bat_d   = 1'b0;
        err_d   = 1'b0;
        if (rx_valid) begin
            if (state_q == ST_PAUSE) begin
                if (cnt_q <= 3'd1) begin
                    push_d  = 1'b1;
                    ev_d    = '{ext: 1'b1, brk: 1'b0, code: PS2_PAUSE};
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end else begin
                case (rx_data)
                    PS2_EXT:   state_d = ST_EXT;
                    PS2_BRK: begin
                        if (state_q == ST_IDLE)     state_d = ST_BRK;
                        else if (state_q == ST_EXT) state_d = ST_EXT_BRK;
                    end
                    PS2_PAUSE: begin
                        state_d = ST_PAUSE;
                        cnt_d   = PAUSE_TAIL;
                    end
                    PS2_ERR0, PS2_ERR1: begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                    PS2_ACK:   ack_d = 1'b1;
                    default: begin
                        if (rx_data == PS2_BAT && state_q == ST_IDLE) begin
                            bat_d = 1'b1;
                        end else begin
                            push_d  = 1'b1;
                            ev_d.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                            ev_d.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
                            ev_d.code = rx_data;
                            state_d = ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Decoder state, status pulses and sticky flags (a same-cycle set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            bat_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            bat_q   <= bat_d;
            if (err_d)          err_q <= 1'b1;
            else if (clr_flags) err_q <= 1'b0;
            if (push_d && fifo_full && !ev_ready) ovf_q <= 1'b1;
            else if (clr_flags)                   ovf_q <= 1'b0;
        end
    end

    ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_d),
        .din_i   (ev_d),
        .pop_i   (ev_ready),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (ev_level)
    );

    assign ev_code   = head.code;
    assign ev_ext    = head.ext;
    assign ev_break  = head.brk;
    assign ev_valid  = ~fifo_empty;
    assign ack_pulse = ack_q;
    assign bat_pulse = bat_q;
    assign kbd_err   = err_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for the PS/2 scan code decoder.
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext, ev_break, ev_valid;
    logic       ev_ready = 1'b0;
    logic [3:0] ev_level;
    logic       ack_pulse, bat_pulse, kbd_err, overflow;
    logic       clr_flags = 1'b0;

    int checks = 0;
    int failures = 0;

    ps2_scancode_decoder #(.DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_level  (ev_level),
        .ack_pulse (ack_pulse),
        .bat_pulse (bat_pulse),
        .kbd_err   (kbd_err),
        .overflow  (overflow),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for one cycle; returns 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Check the head event, then pop it.
    task automatic pop_chk(input string tag, input logic [7:0] code, input logic ext, input logic brk);
        chk({tag, "_valid"}, ev_valid, 1'b1);
        chk({tag, "_code"},  ev_code,  code);
        chk({tag, "_ext"},   ev_ext,   ext);
        chk({tag, "_brk"},   ev_break, brk);
        ev_ready = 1'b1;
        @(posedge clk);
        #1;
        ev_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", ev_valid, 1'b0);
        chk("rst_level", ev_level, 4'd0);
        chk("rst_code",  ev_code,  8'h00);
        chk("rst_flags", {ack_pulse, bat_pulse, kbd_err, overflow}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Plain make code
        chk("mk_valid_before", ev_valid, 1'b0);
        send(8'h1C);
        pop_chk("mk1c", 8'h1C, 1'b0, 1'b0);
        chk("mk_level_after", ev_level, 4'd0);

        // Extended break
        send(8'hE0);
        send(8'hF0);
        chk("eb_prefix_level", ev_level, 4'd0);
        send(8'h75);
        chk("eb_level", ev_level, 4'd1);
        pop_chk("eb75", 8'h75, 1'b1, 1'b1);
        chk("eb_level_after", ev_level, 4'd0);

        // Pause sequence: one event only after the 8th byte
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        chk("pause_level_7", ev_level, 4'd0);
        send(8'h77);
        chk("pause_level_8", ev_level, 4'd1);
        pop_chk("pause", 8'hE1, 1'b1, 1'b0);
        chk("pause_level_after", ev_level, 4'd0);

        // Status bytes
        ev_ready = 1'b1;
        send(8'hFA);
        chk("ack_hi", {ack_pulse, bat_pulse}, 2'b10);
        send(8'hAA);
        chk("bat_hi", {ack_pulse, bat_pulse}, 2'b01);
        send(8'hFF);
        chk("err_set", {ack_pulse, bat_pulse, kbd_err}, 3'b001);
        chk("status_level", ev_level, 4'd0);
        ev_ready = 1'b0;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        chk("err_clr", kbd_err, 1'b0);

        // Error in the clear cycle keeps the flag
        clr_flags = 1'b1;
        send(8'h00);
        clr_flags = 1'b0;
        chk("err_prio", kbd_err, 1'b1);
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        chk("err_clr2", kbd_err, 1'b0);

        // AA after E0 is an ordinary code; FA keeps the prefix
        send(8'hE0);
        send(8'hAA);
        chk("aa_ext_bat", bat_pulse, 1'b0);
        pop_chk("aa_ext", 8'hAA, 1'b1, 1'b0);
        send(8'hE0);
        send(8'hFA);
        chk("fa_ext_ack", ack_pulse, 1'b1);
        send(8'h6B);
        pop_chk("fa_ext", 8'h6B, 1'b1, 1'b0);

        // Overflow: 9 codes into 8 entries
        for (int i = 1; i <= 9; i++) send(8'(i));
        chk("ovf_level", ev_level, 4'd8);
        chk("ovf_flag", overflow, 1'b1);
        for (int i = 1; i <= 8; i++) pop_chk("drain", 8'(i), 1'b0, 1'b0);
        chk("drain_level", ev_level, 4'd0);
        chk("drain_valid", ev_valid, 1'b0);
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        chk("ovf_clr", overflow, 1'b0);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
        chk("fullpp_pre", ev_level, 4'd8);
        ev_ready = 1'b1;
        send(8'h2A);
        ev_ready = 1'b0;
        chk("fullpp_level", ev_level, 4'd8);
        chk("fullpp_ovf", overflow, 1'b0);
        for (int i = 1; i < 8; i++) pop_chk("fullpp_drain", 8'h10 + 8'(i), 1'b0, 1'b0);
        pop_chk("fullpp_last", 8'h2A, 1'b0, 1'b0);
        chk("fullpp_empty", ev_valid, 1'b0);

        // Reset mid-prefix with a queued event
        send(8'h33);
        send(8'hE0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        chk("rst_mid_level", ev_level, 4'd0);
        chk("rst_mid_valid", ev_valid, 1'b0);
        @(posedge clk); #1;
        send(8'h75);
        pop_chk("rst_mid", 8'h75, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
